input_cmd_scheduler: RTL and testbench

Serializes the one-cycle button pulses from the 12-button input validator into an ordered command stream for the Sudoku game logic. Simultaneous pulses are queued lowest-index first in a small FIFO. Commands are issued over a valid/ready handshake. The block drives the validator's `block_controller` input to throttle new presses while it is backlogged, disabled or in post-enable holdoff.

---
 rtl/input_cmd_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_input_cmd_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/input_cmd_scheduler.sv
// Serializes one-cycle button pulses into an ordered command stream over valid/ready.
// Simultaneous pulses are queued lowest index first; block_controller throttles the validator.
module input_cmd_scheduler #(
    parameter int FIFO_DEPTH     = 4,
    parameter int HOLDOFF_CYCLES = 50_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [11:0]                   btn_pulse,
    input  logic                          cmd_ready,
    output logic                          block_controller,
    output logic                          cmd_valid,
    output logic [3:0]                    cmd_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(HOLDOFF_CYCLES) + 1;

    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);

    localparam logic [1:0] S_DISABLED = 2'd0;
    localparam logic [1:0] S_HOLDOFF  = 2'd1;
    localparam logic [1:0] S_RUN      = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic [11:0]   pending_q, pending_d;
    logic [3:0]    fifo_q [FIFO_DEPTH];
    logic [3:0]    fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    drop_count_q, drop_count_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [3:0]    cmd_code_q, cmd_code_d;
    logic          block_q, block_d;

    logic          run_s;
    logic          pop_s;
    logic          push_ok_s;
    logic          push_s;
    logic [3:0]    push_idx_s;
    logic [11:0]   push_mask_s;
    logic          drop_s;

    function automatic logic [3:0] lowest_idx(input logic [11:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Handshake, push eligibility and drop detection for the current edge.
    always_comb begin
        run_s       = (state_q == S_RUN) && enable;
        pop_s       = run_s && cmd_valid_q && cmd_ready;
        push_ok_s   = (level_q < DEPTH_L) || ((level_q == DEPTH_L) && pop_s);
        push_s      = run_s && (pending_q != 12'd0) && push_ok_s;
        push_idx_s  = lowest_idx(pending_q);
        if (push_s) begin
            push_mask_s = 12'd1 << push_idx_s;
        end else begin
            push_mask_s = 12'd0;
        end
        drop_s      = run_s && ((btn_pulse & pending_q & ~push_mask_s) != 12'd0);
    end

    // Next-state logic for the mode FSM, pending set, FIFO and drop counter.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        pending_d    = pending_q;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        drop_count_d = drop_count_q;

        case (state_q)
            S_DISABLED: begin
                pending_d  = 12'd0;
                hold_cnt_d = {CW{1'b0}};
                wr_ptr_d   = {PW{1'b0}};
                rd_ptr_d   = {PW{1'b0}};
                level_d    = {LW{1'b0}};
                if (enable) begin
                    state_d = S_HOLDOFF;
                end else begin
                    state_d = S_DISABLED;
                end
            end
            S_HOLDOFF: begin
                if (!enable) begin
                    state_d    = S_DISABLED;
                    hold_cnt_d = {CW{1'b0}};
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = S_RUN;
                    hold_cnt_d = {CW{1'b0}};
                end else begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_d   = S_DISABLED;
                    pending_d = 12'd0;
                    wr_ptr_d  = {PW{1'b0}};
                    rd_ptr_d  = {PW{1'b0}};
                    level_d   = {LW{1'b0}};
                end else begin
                    pending_d = (pending_q & ~push_mask_s) | btn_pulse;
                    if (drop_s && (drop_count_q != 8'hFF)) begin
                        drop_count_d = drop_count_q + 8'd1;
                    end else begin
                        drop_count_d = drop_count_q;
                    end
                    if (push_s) begin
                        fifo_d[wr_ptr_q] = push_idx_s;
                        wr_ptr_d         = wr_ptr_q + PW'(1);
                    end else begin
                        wr_ptr_d = wr_ptr_q;
                    end
                    if (pop_s) begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end else begin
                        rd_ptr_d = rd_ptr_q;
                    end
                    if (push_s && !pop_s) begin
                        level_d = level_q + LW'(1);
                    end else if (pop_s && !push_s) begin
                        level_d = level_q - LW'(1);
                    end else begin
                        level_d = level_q;
                    end
                end
            end
            default: begin
                state_d    = S_DISABLED;
                pending_d  = 12'd0;
                hold_cnt_d = {CW{1'b0}};
                wr_ptr_d   = {PW{1'b0}};
                rd_ptr_d   = {PW{1'b0}};
                level_d    = {LW{1'b0}};
            end
        endcase
    end

    // Outputs are precomputed from next-state values so they come straight from flops.
    always_comb begin
        cmd_valid_d = (level_d != {LW{1'b0}});
        if (cmd_valid_d) begin
            cmd_code_d = fifo_d[rd_ptr_d];
        end else begin
            cmd_code_d = 4'd0;
        end
        block_d = (state_d != S_RUN) || (pending_d != 12'd0) ||
                  (level_d >= (DEPTH_L - LW'(1)));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_DISABLED;
            hold_cnt_q   <= {CW{1'b0}};
            pending_q    <= 12'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= 4'd0;
            end
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            level_q      <= {LW{1'b0}};
            drop_count_q <= 8'd0;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= 4'd0;
            block_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            pending_q    <= pending_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            drop_count_q <= drop_count_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            block_q      <= block_d;
        end
    end

    assign block_controller = block_q;
    assign cmd_valid        = cmd_valid_q;
    assign cmd_code         = cmd_code_q;
    assign fifo_level       = level_q;
    assign drop_count       = drop_count_q;

endmodule

// File: tb/tb_input_cmd_scheduler.sv
// Scoreboard bench for input_cmd_scheduler: expected codes queued at stimulus time,
// compared in order whenever the DUT completes a handshake.
module tb_input_cmd_scheduler;

    localparam int DEPTH = 4;
    localparam int HOLD  = 8;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [11:0] btn_pulse;
    logic        cmd_ready;
    logic        block_controller;
    logic        cmd_valid;
    logic [3:0]  cmd_code;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_count;

    int          n_checks;
    int          n_fail;
    logic [3:0]  sb_q [$];

    input_cmd_scheduler #(
        .FIFO_DEPTH     (DEPTH),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .btn_pulse        (btn_pulse),
        .cmd_ready        (cmd_ready),
        .block_controller (block_controller),
        .cmd_valid        (cmd_valid),
        .cmd_code         (cmd_code),
        .fifo_level       (fifo_level),
        .drop_count       (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every completed handshake must deliver the oldest expected command.
    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check("pop_code", {28'd0, cmd_code}, {28'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic pulse(input logic [11:0] bits);
        btn_pulse = bits;
        tick();
        btn_pulse = 12'd0;
    endtask

    task automatic holdoff_run();
        enable = 1'b1;
        for (int i = 0; i <= HOLD; i++) begin
            if (i == HOLD) btn_pulse = 12'h001;
            tick();
            btn_pulse = 12'd0;
            check("holdoff_block", {31'd0, block_controller}, (i < HOLD) ? 32'd1 : 32'd0);
        end
        tick();
        check("holdoff_edge_pulse_level", {29'd0, fifo_level}, 32'd0);
        check("holdoff_edge_pulse_block", {31'd0, block_controller}, 32'd0);
    endtask

    task automatic drain(input string tag);
        int n;
        cmd_ready = 1'b1;
        n = 0;
        while ((cmd_valid || block_controller) && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_drain_timeout"}, {31'd0, (n >= 20)}, 32'd0);
        check({tag, "_sb_empty"}, sb_q.size(), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        btn_pulse = 12'd0;
        cmd_ready = 1'b0;
        repeat (3) tick();
        check("rst_block", {31'd0, block_controller}, 32'd1);
        check("rst_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_code", {28'd0, cmd_code}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        check("rst_drop", {24'd0, drop_count}, 32'd0);
        reset = 1'b0;
        holdoff_run();

        // Single press, consumer always ready.
        cmd_ready = 1'b1;
        sb_q.push_back(4'd4);
        pulse(12'h010);
        check("single_valid_t", {31'd0, cmd_valid}, 32'd0);
        check("single_block_t", {31'd0, block_controller}, 32'd1);
        tick();
        check("single_valid_t1", {31'd0, cmd_valid}, 32'd1);
        check("single_code_t1", {28'd0, cmd_code}, 32'd4);
        tick();
        check("single_valid_t2", {31'd0, cmd_valid}, 32'd0);
        check("single_drop", {24'd0, drop_count}, 32'd0);

        // Simultaneous presses, consumer stalled.
        cmd_ready = 1'b0;
        sb_q.push_back(4'd0);
        sb_q.push_back(4'd2);
        sb_q.push_back(4'd11);
        pulse(12'h805);
        check("simul_level0", {29'd0, fifo_level}, 32'd0);
        check("simul_block0", {31'd0, block_controller}, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("simul_level", {29'd0, fifo_level}, k);
            check("simul_block", {31'd0, block_controller}, 32'd1);
        end
        cmd_ready = 1'b1;
        tick();
        check("simul_pop_level", {29'd0, fifo_level}, 32'd2);
        check("simul_pop_block", {31'd0, block_controller}, 32'd0);
        drain("simul");

        // Full FIFO with a held pending bit and a drop.
        cmd_ready = 1'b0;
        sb_q.push_back(4'd0);
        sb_q.push_back(4'd1);
        sb_q.push_back(4'd2);
        pulse(12'h007);
        repeat (3) tick();
        sb_q.push_back(4'd5);
        pulse(12'h020);
        tick();
        check("full_level", {29'd0, fifo_level}, 32'd4);
        sb_q.push_back(4'd3);
        pulse(12'h008);
        repeat (2) tick();
        check("full_held_level", {29'd0, fifo_level}, 32'd4);
        check("full_held_block", {31'd0, block_controller}, 32'd1);
        check("full_no_drop", {24'd0, drop_count}, 32'd0);
        pulse(12'h008);
        check("full_drop", {24'd0, drop_count}, 32'd1);
        cmd_ready = 1'b1;
        tick();
        check("full_pushpop_level", {29'd0, fifo_level}, 32'd4);
        drain("full");

        // Stall: head must hold while not accepted.
        cmd_ready = 1'b0;
        sb_q.push_back(4'd8);
        pulse(12'h100);
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stall_valid", {31'd0, cmd_valid}, 32'd1);
            check("stall_code", {28'd0, cmd_code}, 32'd8);
            check("stall_level", {29'd0, fifo_level}, 32'd1);
        end
        drain("stall");

        // Disable mid-queue flushes everything; these commands never reach the consumer.
        cmd_ready = 1'b0;
        pulse(12'h007);
        repeat (3) tick();
        check("dis_pre_level", {29'd0, fifo_level}, 32'd3);
        enable = 1'b0;
        tick();
        check("dis_level", {29'd0, fifo_level}, 32'd0);
        check("dis_valid", {31'd0, cmd_valid}, 32'd0);
        check("dis_block", {31'd0, block_controller}, 32'd1);
        btn_pulse = 12'hFFF;
        repeat (3) tick();
        btn_pulse = 12'd0;
        tick();
        check("dis_drop", {24'd0, drop_count}, 32'd1);
        check("dis_ignore_level", {29'd0, fifo_level}, 32'd0);
        holdoff_run();

        cmd_ready = 1'b1;
        sb_q.push_back(4'd11);
        pulse(12'h800);
        drain("reenable");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
